// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-side front end.
package rf_pkg;
    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Producer, decode-hazard and register-file write-port signals of the write arbiter.
interface rf_write_arbiter_if #(parameter int DEPTH = 2);
    import rf_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
    logic              hazard1;
    logic              hazard2;
    logic              WE3;
    logic [REG_AW-1:0] a3;
    logic [XLEN-1:0]   wd3;
    logic [$clog2(DEPTH):0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, a1, a2,
        input  alu_ready, lsu_ready, hazard1, hazard2, WE3, a3, wd3, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, a1, a2,
        output alu_ready, lsu_ready, hazard1, hazard2, WE3, a3, wd3, fifo_count
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// Load-result FIFO; exposes every slot's rd plus a valid mask for hazard compare.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_req_t                      push_req,
    input  logic                         pop,
    output logic [$clog2(DEPTH):0]       count,
    output wb_req_t                      head,
    output logic [DEPTH-1:0][REG_AW-1:0] entry_rd,
    output logic [DEPTH-1:0]             entry_vld
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t        mem_q [DEPTH];
    wb_req_t        mem_d [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  off [DEPTH];

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = push_req;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            off[i]       = PW'(i) - rptr_q;
            entry_rd[i]  = mem_q[i].rd;
            entry_vld[i] = ({1'b0, off[i]} < count_q);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rptr_q];
endmodule

// File: rtl/rf_write_arbiter.sv
// Merges ALU and load results onto the single register-file write port,
// with load starvation protection and read-after-write hazard flags.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [CW-1:0]                count;
    wb_req_t                      head;
    logic [DEPTH-1:0][REG_AW-1:0] entry_rd;
    logic [DEPTH-1:0]             entry_vld;

    wb_req_t       alu_req, lsu_req, out_q, out_d;
    logic          we_q, we_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          fifo_empty, force_lsu, alu_win, pop, push, lsu_rdy;
    logic          hit1, hit2;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_req  (lsu_req),
        .pop       (pop),
        .count     (count),
        .head      (head),
        .entry_rd  (entry_rd),
        .entry_vld (entry_vld)
    );

    always_comb begin
        alu_req.rd   = bus.alu_rd;
        alu_req.data = bus.alu_data;
        lsu_req.rd   = bus.lsu_rd;
        lsu_req.data = bus.lsu_data;
        fifo_empty   = (count == '0);
        force_lsu    = !fifo_empty && (starve_q >= STARVE_MAX);
        alu_win      = bus.alu_valid && !force_lsu;
        pop          = !alu_win && !fifo_empty;
        lsu_rdy      = (count < CW'(DEPTH)) || pop;
        push         = bus.lsu_valid && lsu_rdy;
    end

    // x0 writes are consumed without touching a3/wd3.
    always_comb begin
        out_d = out_q;
        we_d  = 1'b0;
        if (alu_win) begin
            we_d = (alu_req.rd != ZERO_REG);
            if (we_d) out_d = alu_req;
        end else if (pop) begin
            we_d = (head.rd != ZERO_REG);
            if (we_d) out_d = head;
        end
    end

    always_comb begin
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q < STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            we_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            out_q    <= out_d;
            we_q     <= we_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && entry_rd[i] == bus.a1) hit1 = 1'b1;
            if (entry_vld[i] && entry_rd[i] == bus.a2) hit2 = 1'b1;
        end
        if (we_q && out_q.rd == bus.a1) hit1 = 1'b1;
        if (we_q && out_q.rd == bus.a2) hit2 = 1'b1;
        if (alu_win && bus.alu_rd == bus.a1) hit1 = 1'b1;
        if (alu_win && bus.alu_rd == bus.a2) hit2 = 1'b1;
        if (push && bus.lsu_rd == bus.a1) hit1 = 1'b1;
        if (push && bus.lsu_rd == bus.a2) hit2 = 1'b1;
    end

    assign bus.alu_ready  = !force_lsu;
    assign bus.lsu_ready  = lsu_rdy;
    assign bus.hazard1    = hit1 && (bus.a1 != ZERO_REG) && !reset;
    assign bus.hazard2    = hit2 && (bus.a2 != ZERO_REG) && !reset;
    assign bus.WE3        = we_q;
    assign bus.a3         = out_q.rd;
    assign bus.wd3        = out_q.data;
    assign bus.fifo_count = count;
endmodule
